// File: rtl/macc_error_monitor.sv
// Streaming error-metric engine: accumulates count, sum |e|, sum e^2 and max |e| between
// golden and approximate MACC outputs over a programmable, valid-qualified window.
module macc_error_monitor #(
  parameter int W      = 16,
  parameter int SIGNED = 0,
  parameter int SKIP   = 2,
  parameter int CNT_W  = 32,
  parameter int SAE_W  = 48,
  parameter int SSE_W  = 64
) (
  input  logic             Clk,
  input  logic             aclr_n,
  input  logic             clr,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] window_len,
  input  logic             in_valid,
  input  logic [W-1:0]     ref_data,
  input  logic [W-1:0]     dut_data,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [SAE_W-1:0] sae,
  output logic [SSE_W-1:0] sse,
  output logic [W:0]       max_ae,
  output logic             sat
);

  typedef enum logic [2:0] {S_IDLE, S_SKIP, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam int SKIP_W    = (SKIP > 1) ? $clog2(SKIP) : 1;
  localparam int SQ_W      = 2 * W + 2;
  localparam int SAE_SUM_W = ((SAE_W > W + 1) ? SAE_W : W + 1) + 1;
  localparam int SSE_SUM_W = ((SSE_W > SQ_W) ? SSE_W : SQ_W) + 1;

  state_e             state_q, state_d;
  logic [SKIP_W-1:0]  skip_cnt_q, skip_cnt_d;
  logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]   win_len_q, win_len_d;
  logic               drain_q, drain_d;
  logic               accept, clear_acc, open_ended;

  // Control FSM.
  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    run_cnt_d  = run_cnt_q;
    win_len_d  = win_len_q;
    drain_d    = drain_q;
    accept     = 1'b0;
    clear_acc  = 1'b0;
    open_ended = (win_len_q == '0);
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          clear_acc  = 1'b1;
          win_len_d  = window_len;
          skip_cnt_d = '0;
          run_cnt_d  = '0;
          drain_d    = 1'b0;
          state_d    = (SKIP == 0) ? S_RUN : S_SKIP;
        end
      end
      S_SKIP: begin
        if (stop && open_ended) begin
          state_d = S_DRAIN;
        end else if (in_valid) begin
          if (skip_cnt_q == SKIP_W'(SKIP - 1)) state_d = S_RUN;
          else skip_cnt_d = skip_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        accept = in_valid;
        if (in_valid) run_cnt_d = run_cnt_q + 1'b1;
        if ((stop && open_ended) ||
            (!open_ended && in_valid && run_cnt_q == win_len_q - 1'b1))
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        drain_d = ~drain_q;
        if (drain_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (clr) begin
      state_d   = S_IDLE;
      accept    = 1'b0;
      clear_acc = 1'b1;
    end
  end

  // Stage 1: absolute error at W+1 bits; subtracting smaller from larger keeps it unsigned.
  logic [W:0] ref_x, dut_x, ae_d, ae_q;
  logic       ref_ge, s1_valid_q;

  always_comb begin
    ref_x  = (SIGNED != 0) ? {ref_data[W-1], ref_data} : {1'b0, ref_data};
    dut_x  = (SIGNED != 0) ? {dut_data[W-1], dut_data} : {1'b0, dut_data};
    ref_ge = (SIGNED != 0) ? ($signed(ref_x) >= $signed(dut_x)) : (ref_x >= dut_x);
    ae_d   = ref_ge ? (ref_x - dut_x) : (dut_x - ref_x);
  end

  // Stage 2: saturating accumulation, sums computed one bit wider to detect overflow.
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SAE_W-1:0]     sae_q, sae_d;
  logic [SSE_W-1:0]     sse_q, sse_d;
  logic [W:0]           max_q, max_d;
  logic                 sat_q, sat_d;
  logic [SQ_W-1:0]      sq;
  logic [SAE_SUM_W-1:0] sae_sum;
  logic [SSE_SUM_W-1:0] sse_sum;
  logic                 sae_ovf, sse_ovf;

  always_comb begin
    sq      = SQ_W'(ae_q) * SQ_W'(ae_q);
    sae_sum = SAE_SUM_W'(sae_q) + SAE_SUM_W'(ae_q);
    sse_sum = SSE_SUM_W'(sse_q) + SSE_SUM_W'(sq);
    sae_ovf = sae_sum > SAE_SUM_W'({SAE_W{1'b1}});
    sse_ovf = sse_sum > SSE_SUM_W'({SSE_W{1'b1}});
    cnt_d   = cnt_q;
    sae_d   = sae_q;
    sse_d   = sse_q;
    max_d   = max_q;
    sat_d   = sat_q;
    if (clear_acc) begin
      cnt_d = '0;
      sae_d = '0;
      sse_d = '0;
      max_d = '0;
      sat_d = 1'b0;
    end else if (s1_valid_q) begin
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      sae_d = sae_ovf ? '1 : sae_sum[SAE_W-1:0];
      sse_d = sse_ovf ? '1 : sse_sum[SSE_W-1:0];
      if (ae_q > max_q) max_d = ae_q;
      sat_d = sat_q | sae_ovf | sse_ovf;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees
  // pre-edge values of its neighbours regardless of statement order.
  // NOTE: all registers, datapath included, take the async reset so outputs read 0 at once.
  always_ff @(posedge Clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q    <= S_IDLE;
      skip_cnt_q <= '0;
      run_cnt_q  <= '0;
      win_len_q  <= '0;
      drain_q    <= 1'b0;
      s1_valid_q <= 1'b0;
      ae_q       <= '0;
      cnt_q      <= '0;
      sae_q      <= '0;
      sse_q      <= '0;
      max_q      <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
      run_cnt_q  <= run_cnt_d;
      win_len_q  <= win_len_d;
      drain_q    <= drain_d;
      s1_valid_q <= accept;
      if (accept) ae_q <= ae_d;
      cnt_q      <= cnt_d;
      sae_q      <= sae_d;
      sse_q      <= sse_d;
      max_q      <= max_d;
      sat_q      <= sat_d;
    end
  end

  assign busy       = (state_q == S_SKIP) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done       = (state_q == S_DONE);
  assign sample_cnt = cnt_q;
  assign sae        = sae_q;
  assign sse        = sse_q;
  assign max_ae     = max_q;
  assign sat        = sat_q;

endmodule
